// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: splits wide accesses into two memory words, runs the
// three-word interrupt push, and stalls the upstream buffers until done.
module mem_stage_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic                  req_int,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [31:0]           pc_in,
  input  logic [3:0]            flags_in,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2*DATA_W-1:0]   rdata,
  output logic                  rdata_valid,
  output logic                  sp_update,
  output logic [1:0]            sp_words,
  output logic                  stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_I0,
    S_I1,
    S_I2,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_INT
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic                wide_q, wide_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]         pc_q, pc_d;
  logic [3:0]          flags_q, flags_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      wide_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wide_q  <= wide_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wide_d      = wide_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    rdata_d     = rdata_q;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rdata_valid = 1'b0;
    sp_update   = 1'b0;
    sp_words    = 2'd0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_read || req_write || req_int) begin
          stall   = 1'b1;
          base_d  = base_addr;
          wdata_d = wdata;
          pc_d    = pc_in;
          flags_d = flags_in;
          wide_d  = req_wide;
          if (req_int) begin
            op_d    = OP_INT;
            state_d = S_I0;
          end else begin
            op_d    = req_write ? OP_WRITE : OP_READ;
            state_d = S_W0;
          end
        end
      end

      S_W0: begin
        stall    = 1'b1;
        mem_addr = base_q;
        mem_re   = (op_q == OP_READ);
        mem_we   = (op_q == OP_WRITE);
        if (op_q == OP_WRITE)
          mem_wdata = wide_q ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
        if (mem_ack) begin
          // Wide loads fill the high half first; narrow loads zero-extend.
          if (op_q == OP_READ)
            rdata_d = wide_q ? {mem_rdata, {DATA_W{1'b0}}}
                             : {{DATA_W{1'b0}}, mem_rdata};
          state_d = wide_q ? S_W1 : S_DONE;
        end
      end

      S_W1: begin
        stall    = 1'b1;
        mem_addr = base_q + ADDR_W'(1);
        mem_re   = (op_q == OP_READ);
        mem_we   = (op_q == OP_WRITE);
        if (op_q == OP_WRITE)
          mem_wdata = wdata_q[DATA_W-1:0];
        if (mem_ack) begin
          if (op_q == OP_READ)
            rdata_d = {rdata_q[2*DATA_W-1:DATA_W], mem_rdata};
          state_d = S_DONE;
        end
      end

      S_I0: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q;
        mem_wdata = DATA_W'(pc_q[31:16]);
        if (mem_ack) state_d = S_I1;
      end

      S_I1: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q - ADDR_W'(1);
        mem_wdata = DATA_W'(pc_q[15:0]);
        if (mem_ack) state_d = S_I2;
      end

      S_I2: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q - ADDR_W'(2);
        mem_wdata = DATA_W'(flags_q);
        if (mem_ack) state_d = S_DONE;
      end

      S_DONE: begin
        rdata_valid = (op_q == OP_READ);
        sp_update   = (op_q == OP_INT);
        sp_words    = (op_q == OP_INT) ? 2'd3 : 2'd0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Scoreboard bench for mem_stage_sequencer: a responder models memory,
// a monitor checks every strobe and result pulse against queued expectations.
module tb_mem_stage_sequencer;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_LD = 2;
  localparam int K_SP = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write, req_wide, req_int;
  logic [31:0] base_addr;
  logic [31:0] wdata;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [31:0] rdata;
  logic        rdata_valid, sp_update;
  logic [1:0]  sp_words;
  logic        stall;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [15:0] rd_q[$];
  int   ack_delay = 0;
  int   ack_cnt = 0;
  bit   hold_ack = 1'b0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_stage_sequencer #(.ADDR_W(32), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_wide(req_wide), .req_int(req_int),
    .base_addr(base_addr), .wdata(wdata), .pc_in(pc_in), .flags_in(flags_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .sp_update(sp_update),
    .sp_words(sp_words), .stall(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_stall"}, 32'(stall), 32'd0);
    chk({name, "_strobes"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({name, "_addr"}, mem_addr, 32'd0);
    chk({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({name, "_rdata"}, rdata, 32'd0);
    chk({name, "_pulses"}, {29'd0, rdata_valid, sp_update, 1'b0}, 32'd0);
    chk({name, "_sp_words"}, 32'(sp_words), 32'd0);
  endtask

  // Memory responder: acks a held strobe after ack_delay waiting cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h5A5A;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !(mem_re || mem_we)) begin
        mem_ack = 1'b0; ack_cnt = 0; mem_rdata = 16'h5A5A;
      end else if (hold_ack) begin
        mem_ack = 1'b0; mem_rdata = 16'h5A5A;
      end else if (ack_cnt == ack_delay) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        mem_rdata = (mem_re && rd_q.size() > 0) ? rd_q.pop_front() : 16'h5A5A;
      end else begin
        mem_ack = 1'b0; ack_cnt++; mem_rdata = 16'h5A5A;
      end
    end
  end

  // Monitor: every strobe cycle is checked against the head of the queue,
  // popped only when the word completes.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_re || mem_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {30'd0, mem_we, mem_re}, 32'd0);
          end else begin
            e = exp_q[0];
            chk("strobe_kind", {30'd0, mem_we, mem_re}, (e.kind == K_WR) ? 32'd2 : 32'd1);
            chk("mem_addr", mem_addr, e.addr);
            if (e.kind == K_WR) chk("mem_wdata", 32'(mem_wdata), e.data);
            if (mem_ack) void'(exp_q.pop_front());
          end
        end
        if (rdata_valid) begin
          if (exp_q.size() == 0 || exp_q[0].kind != K_LD) begin
            chk("unexpected_rdata_valid", 32'd1, 32'd0);
          end else begin
            chk("rdata", rdata, exp_q[0].data);
            void'(exp_q.pop_front());
          end
        end
        if (sp_update) begin
          if (exp_q.size() == 0 || exp_q[0].kind != K_SP) begin
            chk("unexpected_sp_update", 32'd1, 32'd0);
          end else begin
            chk("sp_words", 32'(sp_words), exp_q[0].data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run_op(input bit rd, input bit wr, input bit wide, input bit irq,
                        input logic [31:0] base, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [3:0] fl,
                        input int exp_stall, input string name);
    int n = 0;
    bit done = 1'b0;
    @(posedge clk);
    #2;
    req_read = rd; req_write = wr; req_wide = wide; req_int = irq;
    base_addr = base; wdata = wd; pc_in = pc; flags_in = fl;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    req_read = 1'b0; req_write = 1'b0; req_wide = 1'b0; req_int = 1'b0;
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
  endtask

  initial begin
    reset = 1'b1;
    req_read = 1'b0; req_write = 1'b0; req_wide = 1'b0; req_int = 1'b0;
    base_addr = '0; wdata = '0; pc_in = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;

    ack_delay = 0;
    rd_q.push_back(16'hBEEF);
    push(K_RD, 32'h10, 32'h0);
    push(K_LD, 32'h0, 32'h0000BEEF);
    run_op(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 4'h0, 2, "narrow_read");

    push(K_WR, 32'h3, 32'h1357);
    run_op(0, 1, 0, 0, 32'h3, 32'hFFFF1357, 32'h0, 4'h0, 2, "narrow_write");

    push(K_WR, 32'h40, 32'h2468);
    run_op(1, 1, 0, 0, 32'h40, 32'h00002468, 32'h0, 4'h0, 2, "read_write");

    push(K_WR, 32'hFFFFFFFF, 32'h1234);
    push(K_WR, 32'h00000000, 32'h5678);
    run_op(0, 1, 1, 0, 32'hFFFFFFFF, 32'h12345678, 32'h0, 4'h0, 3, "wide_write_wrap");

    push(K_WR, 32'h7FF, 32'h0000);
    push(K_WR, 32'h7FE, 32'hA5C3);
    push(K_WR, 32'h7FD, 32'h0005);
    push(K_SP, 32'h0, 32'd3);
    run_op(0, 0, 0, 1, 32'h7FF, 32'h0, 32'h0000A5C3, 4'h5, 4, "interrupt");

    push(K_WR, 32'h00000001, 32'hFFFF);
    push(K_WR, 32'h00000000, 32'h0001);
    push(K_WR, 32'hFFFFFFFF, 32'h000F);
    push(K_SP, 32'h0, 32'd3);
    run_op(0, 0, 0, 1, 32'h1, 32'h0, 32'hFFFF0001, 4'hF, 4, "interrupt_wrap");

    ack_delay = 3;
    rd_q.push_back(16'hDEAD);
    rd_q.push_back(16'hF00D);
    push(K_RD, 32'h2000, 32'h0);
    push(K_RD, 32'h2001, 32'h0);
    push(K_LD, 32'h0, 32'hDEADF00D);
    run_op(1, 0, 1, 0, 32'h2000, 32'h0, 32'h0, 4'h0, 9, "wide_read_slow");
    ack_delay = 0;

    rd_q.push_back(16'h0042);
    push(K_RD, 32'h55, 32'h0);
    push(K_LD, 32'h0, 32'h00000042);
    run_op(1, 0, 0, 0, 32'h55, 32'h0, 32'h0, 4'h0, 2, "narrow_after_wide");

    push(K_WR, 32'h20, 32'h1234);
    push(K_WR, 32'h1F, 32'h5678);
    push(K_WR, 32'h1E, 32'h000A);
    push(K_SP, 32'h0, 32'd3);
    run_op(1, 1, 1, 1, 32'h20, 32'hFFFFFFFF, 32'h12345678, 4'hA, 4, "all_reqs");

    // Reset in W1 of a wide write: second word is seen but never completes.
    push(K_WR, 32'h100, 32'hCAFE);
    push(K_WR, 32'h101, 32'hBABE);
    @(posedge clk);
    #2;
    req_write = 1'b1; req_wide = 1'b1; base_addr = 32'h100; wdata = 32'hCAFEBABE;
    @(negedge clk);
    @(negedge clk);
    hold_ack = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    req_write = 1'b0; req_wide = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("reset_abort_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check_idle("after_abort");
    hold_ack = 1'b0;
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("read_data_consumed", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
